// File: rtl/ad7763_pkg.sv
// ad7763_pkg
// Shared definitions for the AD7763 control-word arbiter:
//   - arbiter state encoding
//   - control-word field positions ([31:16] register address, [15:0] data)
//   - AD7763 register addresses used by the power-up sequence
//   - grant_id value reported while the power-up sequence runs
//   - cw_make(): builds a control word from address and data
package ad7763_pkg;

  typedef enum logic [2:0] {
    ST_INIT_ISSUE = 3'd0,
    ST_IDLE       = 3'd1,
    ST_ISSUE      = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_GAP        = 3'd4
  } arb_state_e;

  localparam int ADDR_MSB = 31;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;

  localparam logic [15:0] REG_CTRL1 = 16'h0001;
  localparam logic [15:0] REG_CTRL2 = 16'h0002;

  localparam logic [2:0] GRANT_INIT = 3'd7;

  function automatic logic [31:0] cw_make(input logic [15:0] addr, input logic [15:0] data);
    logic [31:0] word_s;
    word_s = 32'h0000_0000;
    word_s[ADDR_MSB:ADDR_LSB] = addr;
    word_s[DATA_MSB:0] = data;
    return word_s;
  endfunction

endpackage

// File: rtl/ad7763_rr_pick.sv
// ad7763_rr_pick
// Combinational round-robin picker: selects the first asserted request at or
// after the pointer position, wrapping around.
// Ports:
//   req        in   NUM_REQ  request vector
//   ptr        in   3        round-robin start position (always < NUM_REQ)
//   grant      out  NUM_REQ  one-hot selection (all zero when no request)
//   grant_idx  out  3        index of the selected request
//   grant_any  out  1        at least one request is asserted
module ad7763_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         grant_idx,
  output logic               grant_any
);

  localparam logic [3:0] NUM_REQ_W = 4'(NUM_REQ);

  logic [3:0] pos_s;
  logic       found_s;

  // Scan positions ptr, ptr+1, ... (mod NUM_REQ) and take the first request.
  always_comb begin
    grant     = '0;
    grant_idx = 3'd0;
    found_s   = 1'b0;
    pos_s     = 4'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos_s = {1'b0, ptr} + 4'(k);
      if (pos_s >= NUM_REQ_W) begin
        pos_s = pos_s - NUM_REQ_W;
      end else begin
        pos_s = pos_s;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found_s && (pos_s == 4'(i)) && req[i]) begin
          grant[i]  = 1'b1;
          grant_idx = 3'(i);
          found_s   = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  assign grant_any = found_s;

endmodule

// File: rtl/ad7763_ctrl_arbiter.sv
// ad7763_ctrl_arbiter
// Shares the AD7763 control-word path between NUM_REQ requesters. After reset
// it issues INIT_WORDS power-up words, then grants requesters round-robin and
// forwards one 32-bit word at a time, waiting for m_done (or a timeout) and a
// minimum gap before the next word.
// Ports:
//   aclk, aresetn   clock, asynchronous active-low reset
//   req_valid/data  per-requester word valid / word (requester i at [32*i+31:32*i])
//   req_ready       one-hot, single-cycle acceptance pulse
//   m_valid/m_data  word to serializer, m_ready accepts it
//   m_done          serializer finished the frame (single-cycle pulse)
//   busy            high in every state except IDLE
//   init_done       power-up sequence complete
//   grant_id        last granted requester, 7 while initializing
//   err_timeout     sticky timeout flag, cleared by err_clr
module ad7763_ctrl_arbiter
  import ad7763_pkg::*;
#(
  parameter int          NUM_REQ        = 2,
  parameter int          GAP_CYCLES     = 64,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter int          INIT_WORDS     = 2,
  parameter logic [31:0] INIT_WORD0     = cw_make(REG_CTRL1, 16'h0002),
  parameter logic [31:0] INIT_WORD1     = cw_make(REG_CTRL2, 16'h0000),
  parameter logic [31:0] INIT_WORD2     = 32'h0000_0000,
  parameter logic [31:0] INIT_WORD3     = 32'h0000_0000
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    m_valid,
  output logic [31:0]             m_data,
  input  logic                    m_ready,
  input  logic                    m_done,
  output logic                    busy,
  output logic                    init_done,
  output logic [2:0]              grant_id,
  output logic                    err_timeout,
  input  logic                    err_clr
);

  localparam logic [15:0] GAP_LAST      = 16'(GAP_CYCLES - 1);
  localparam logic [19:0] TMO_LAST      = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  INIT_LAST     = 2'(INIT_WORDS - 1);
  localparam logic [2:0]  REQ_LAST      = 3'(NUM_REQ - 1);
  localparam arb_state_e  RST_STATE     = (INIT_WORDS > 0) ? ST_INIT_ISSUE : ST_IDLE;
  localparam logic        RST_INIT_DONE = (INIT_WORDS == 0);

  arb_state_e           state_r;
  logic [1:0]           init_idx_r;
  logic [2:0]           rr_ptr_r;
  logic [15:0]          gap_cnt_r;
  logic [19:0]          tmo_cnt_r;
  logic                 m_valid_r;
  logic [31:0]          m_data_r;
  logic [NUM_REQ-1:0]   req_ready_r;
  logic                 busy_r;
  logic                 init_done_r;
  logic [2:0]           grant_id_r;
  logic                 err_timeout_r;

  logic [NUM_REQ-1:0]   pick_oh_s;
  logic [2:0]           pick_idx_s;
  logic                 pick_any_s;
  logic [31:0]          pick_data_s;
  logic [31:0]          init_word_s;
  logic [2:0]           rr_next_s;
  logic                 tmo_hit_s;

  ad7763_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .grant     (pick_oh_s),
    .grant_idx (pick_idx_s),
    .grant_any (pick_any_s)
  );

  // Select the data word of the picked requester.
  always_comb begin
    pick_data_s = 32'h0000_0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh_s[i]) begin
        pick_data_s = req_data[32*i +: 32];
      end else begin
        pick_data_s = pick_data_s;
      end
    end
  end

  // Power-up word for the current init index.
  always_comb begin
    case (init_idx_r)
      2'd0:    init_word_s = INIT_WORD0;
      2'd1:    init_word_s = INIT_WORD1;
      2'd2:    init_word_s = INIT_WORD2;
      2'd3:    init_word_s = INIT_WORD3;
      default: init_word_s = 32'h0000_0000;
    endcase
  end

  // Pointer after a grant: one past the winner, wrapping to 0.
  always_comb begin
    if (pick_idx_s == REQ_LAST) begin
      rr_next_s = 3'd0;
    end else begin
      rr_next_s = pick_idx_s + 3'd1;
    end
  end

  // Timeout fires only when the terminal count is reached without m_done.
  always_comb begin
    if ((state_r == ST_WAIT_DONE) && !m_done && (tmo_cnt_r == TMO_LAST)) begin
      tmo_hit_s = 1'b1;
    end else begin
      tmo_hit_s = 1'b0;
    end
  end

  // Main arbiter FSM with registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r       <= RST_STATE;
      init_idx_r    <= 2'd0;
      rr_ptr_r      <= 3'd0;
      gap_cnt_r     <= 16'd0;
      tmo_cnt_r     <= 20'd0;
      m_valid_r     <= 1'b0;
      m_data_r      <= 32'h0000_0000;
      req_ready_r   <= '0;
      busy_r        <= 1'b1;
      init_done_r   <= RST_INIT_DONE;
      grant_id_r    <= GRANT_INIT;
      err_timeout_r <= 1'b0;
    end else begin
      req_ready_r <= '0;

      // err_clr wins over a timeout in the same cycle
      if (err_clr) begin
        err_timeout_r <= 1'b0;
      end else if (tmo_hit_s) begin
        err_timeout_r <= 1'b1;
      end else begin
        err_timeout_r <= err_timeout_r;
      end

      case (state_r)
        ST_INIT_ISSUE, ST_ISSUE: begin
          busy_r <= 1'b1;
          if (m_valid_r && m_ready) begin
            m_valid_r <= 1'b0;
            tmo_cnt_r <= 20'd0;
            state_r   <= ST_WAIT_DONE;
          end else if (state_r == ST_INIT_ISSUE) begin
            m_valid_r <= 1'b1;
            m_data_r  <= init_word_s;
          end else begin
            // requester word was latched at grant; hold it until accepted
            m_valid_r <= 1'b1;
          end
        end

        ST_IDLE: begin
          m_valid_r <= 1'b0;
          if (pick_any_s && init_done_r) begin
            req_ready_r <= pick_oh_s;
            m_data_r    <= pick_data_s;
            grant_id_r  <= pick_idx_s;
            rr_ptr_r    <= rr_next_s;
            busy_r      <= 1'b1;
            state_r     <= ST_ISSUE;
          end else begin
            busy_r <= 1'b0;
          end
        end

        ST_WAIT_DONE: begin
          busy_r <= 1'b1;
          if (m_done || (tmo_cnt_r == TMO_LAST)) begin
            // word is dropped on timeout, no retry
            gap_cnt_r <= 16'd0;
            state_r   <= ST_GAP;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 20'd1;
          end
        end

        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            if (!init_done_r) begin
              if (init_idx_r == INIT_LAST) begin
                init_done_r <= 1'b1;
                busy_r      <= 1'b0;
                state_r     <= ST_IDLE;
              end else begin
                init_idx_r <= init_idx_r + 2'd1;
                busy_r     <= 1'b1;
                state_r    <= ST_INIT_ISSUE;
              end
            end else begin
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end else begin
            busy_r    <= 1'b1;
            gap_cnt_r <= gap_cnt_r + 16'd1;
          end
        end

        default: begin
          m_valid_r <= 1'b0;
          busy_r    <= 1'b1;
          state_r   <= RST_STATE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_r;
  assign m_valid     = m_valid_r;
  assign m_data      = m_data_r;
  assign busy        = busy_r;
  assign init_done   = init_done_r;
  assign grant_id    = grant_id_r;
  assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_ad7763_ctrl_arbiter.sv
// tb_ad7763_ctrl_arbiter
// Self-checking bench: power-up sequence, table of round-robin transactions,
// and hand-written sequences for stall, timeout, coincident done/clear and
// asynchronous reset. Inputs are driven and outputs sampled on the falling edge.
module tb_ad7763_ctrl_arbiter;

  localparam int          GAP   = 8;
  localparam int          TMO   = 64;
  localparam logic [31:0] W0    = 32'h0001_0002;
  localparam logic [31:0] W1    = 32'h0002_0000;
  localparam logic [31:0] DAT_A = 32'h0003_00AA;
  localparam logic [31:0] DAT_B = 32'h0003_00BB;

  typedef struct {
    logic [1:0]  rv;
    logic [31:0] a_dat;
    logic [31:0] b_dat;
    logic [1:0]  exp_ready;
    logic [31:0] exp_data;
    logic [2:0]  exp_gid;
  } vec_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [1:0]  req_valid;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;
  logic        m_done;
  logic        busy;
  logic        init_done;
  logic [2:0]  grant_id;
  logic        err_timeout;
  logic        err_clr;

  int n_pass = 0;
  int n_total = 0;
  int bad_grant = 0;

  always #5 aclk = ~aclk;

  ad7763_ctrl_arbiter #(
    .NUM_REQ        (2),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO),
    .INIT_WORDS     (2),
    .INIT_WORD0     (W0),
    .INIT_WORD1     (W1),
    .INIT_WORD2     (32'h0000_0000),
    .INIT_WORD3     (32'h0000_0000)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .m_done      (m_done),
    .busy        (busy),
    .init_done   (init_done),
    .grant_id    (grant_id),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  // req_ready must never fire before init_done and must be one-hot or zero
  always @(negedge aclk) begin
    if (aresetn === 1'b1 && init_done === 1'b0 && req_ready !== 2'b00) begin
      bad_grant <= bad_grant + 1;
    end else if ($countones(req_ready) > 1) begin
      bad_grant <= bad_grant + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge aclk);
  endtask

  task automatic wait_valid(input string name, output int cyc);
    cyc = 0;
    while (m_valid !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    chk(name, 32'(m_valid), 32'd1);
  endtask

  task automatic wait_ready(input string name, output int cyc);
    cyc = 0;
    while (req_ready === 2'b00 && cyc < 200) begin
      step();
      cyc++;
    end
    chk(name, 32'(req_ready !== 2'b00), 32'd1);
  endtask

  // called at the negedge right after the handshake; m_done sampled n edges later
  task automatic done_after(input int n);
    repeat (n - 1) step();
    m_done = 1'b1;
    step();
    m_done = 1'b0;
  endtask

  task automatic run_init(input string tag);
    int cyc;
    m_ready = 1'b1;
    wait_valid({tag, "_w0_valid"}, cyc);
    chk({tag, "_w0_data"}, m_data, W0);
    chk({tag, "_w0_busy"}, 32'(busy), 32'd1);
    chk({tag, "_w0_gid"}, 32'(grant_id), 32'd7);
    step();
    chk({tag, "_w0_drop"}, 32'(m_valid), 32'd0);
    done_after(40);
    wait_valid({tag, "_w1_valid"}, cyc);
    chk({tag, "_w1_gap"}, 32'(cyc), 32'(GAP + 1));
    chk({tag, "_w1_data"}, m_data, W1);
    chk({tag, "_w1_init_done"}, 32'(init_done), 32'd0);
    step();
    done_after(40);
    repeat (GAP) step();
    chk({tag, "_init_done"}, 32'(init_done), 32'd1);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_gid"}, 32'(grant_id), 32'd7);
  endtask

  task automatic xact(input vec_t v, input string tag, input int exp_wait);
    int cyc;
    req_valid = v.rv;
    req_data  = {v.b_dat, v.a_dat};
    wait_ready({tag, "_grant_wait"}, cyc);
    if (exp_wait > 0) chk({tag, "_grant_lat"}, 32'(cyc), 32'(exp_wait));
    chk({tag, "_ready"}, 32'(req_ready), 32'(v.exp_ready));
    chk({tag, "_gid"}, 32'(grant_id), 32'(v.exp_gid));
    chk({tag, "_data"}, m_data, v.exp_data);
    chk({tag, "_mvalid_lat"}, 32'(m_valid), 32'd0);
    req_data = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    chk({tag, "_ready_pulse"}, 32'(req_ready), 32'd0);
    chk({tag, "_mvalid"}, 32'(m_valid), 32'd1);
    chk({tag, "_data_hold"}, m_data, v.exp_data);
    step();
    done_after(3);
  endtask

  task automatic tmo_case(input string tag, input logic [1:0] exp_ready,
                          input logic do_done, input logic do_clr, input logic exp_err);
    int cyc;
    req_valid = 2'b11;
    req_data  = {DAT_B, DAT_A};
    wait_ready({tag, "_grant_wait"}, cyc);
    chk({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
    step();
    chk({tag, "_mvalid"}, 32'(m_valid), 32'd1);
    step();
    repeat (TMO - 1) step();
    chk({tag, "_err_before"}, 32'(err_timeout), 32'd0);
    m_done  = do_done;
    err_clr = do_clr;
    step();
    m_done  = 1'b0;
    err_clr = 1'b0;
    chk({tag, "_err_after"}, 32'(err_timeout), 32'(exp_err));
  endtask

  vec_t vecs [9];
  vec_t hv;

  initial begin
    int cyc;
    aresetn   = 1'b0;
    req_valid = 2'b00;
    req_data  = 64'h0;
    m_ready   = 1'b0;
    m_done    = 1'b0;
    err_clr   = 1'b0;

    vecs[0] = '{2'b11, DAT_A, DAT_B, 2'b01, DAT_A, 3'd0};
    vecs[1] = '{2'b11, DAT_A, DAT_B, 2'b10, DAT_B, 3'd1};
    vecs[2] = '{2'b11, DAT_A, DAT_B, 2'b01, DAT_A, 3'd0};
    vecs[3] = '{2'b11, DAT_A, DAT_B, 2'b10, DAT_B, 3'd1};
    vecs[4] = '{2'b10, DAT_A, 32'h0003_0055, 2'b10, 32'h0003_0055, 3'd1};
    vecs[5] = '{2'b01, 32'h0003_0011, DAT_B, 2'b01, 32'h0003_0011, 3'd0};
    vecs[6] = '{2'b10, DAT_A, 32'h0001_1234, 2'b10, 32'h0001_1234, 3'd1};
    vecs[7] = '{2'b01, 32'h0002_0F0F, DAT_B, 2'b01, 32'h0002_0F0F, 3'd0};
    vecs[8] = '{2'b01, 32'h0002_00A5, DAT_B, 2'b01, 32'h0002_00A5, 3'd0};

    repeat (3) step();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", m_data, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd7);
    chk("rst_err", 32'(err_timeout), 32'd0);

    // requesters already pending during init: no grant until init_done
    req_valid = 2'b11;
    req_data  = {DAT_B, DAT_A};
    aresetn   = 1'b1;
    run_init("init");

    for (int i = 0; i < 9; i++) begin
      xact(vecs[i], $sformatf("v%0d", i), (i == 0) ? 1 : GAP + 1);
    end

    // serializer stalls m_ready for 10 cycles; pointer is at 1 here
    m_ready   = 1'b0;
    req_valid = 2'b11;
    req_data  = {DAT_B, DAT_A};
    wait_ready("stall_grant_wait", cyc);
    chk("stall_ready", 32'(req_ready), 32'd2);
    step();
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("stall_c%0d_valid", c), 32'(m_valid), 32'd1);
      chk($sformatf("stall_c%0d_data", c), m_data, DAT_B);
      chk($sformatf("stall_c%0d_noreq", c), 32'(req_ready), 32'd0);
      m_done = (c == 4);
      step();
    end
    m_done  = 1'b0;
    m_ready = 1'b1;
    chk("stall_c10_valid", 32'(m_valid), 32'd1);
    step();
    chk("stall_handshake", 32'(m_valid), 32'd0);
    done_after(3);

    // no m_done: timeout, next requester still served, error sticky until cleared
    tmo_case("tmo", 2'b01, 1'b0, 1'b0, 1'b1);
    hv = '{2'b11, DAT_A, DAT_B, 2'b10, DAT_B, 3'd1};
    xact(hv, "after_tmo", GAP + 1);
    chk("err_sticky", 32'(err_timeout), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_cleared", 32'(err_timeout), 32'd0);

    // m_done at terminal count counts as done
    tmo_case("done_at_tc", 2'b01, 1'b1, 1'b0, 1'b0);
    // err_clr at terminal count wins over the timeout set
    tmo_case("clr_at_tc", 2'b10, 1'b0, 1'b1, 1'b0);
    // both together
    tmo_case("both_at_tc", 2'b01, 1'b1, 1'b1, 1'b0);

    // reset during the GAP following requester 1
    hv = '{2'b11, DAT_A, DAT_B, 2'b10, DAT_B, 3'd1};
    xact(hv, "pre_rst", GAP + 1);
    step();
    step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst_m_valid", 32'(m_valid), 32'd0);
    chk("arst_m_data", m_data, 32'h0);
    chk("arst_req_ready", 32'(req_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd1);
    chk("arst_init_done", 32'(init_done), 32'd0);
    chk("arst_grant_id", 32'(grant_id), 32'd7);
    chk("arst_err", 32'(err_timeout), 32'd0);
    step();
    aresetn = 1'b1;
    run_init("reinit");
    hv = '{2'b11, DAT_A, DAT_B, 2'b01, DAT_A, 3'd0};
    xact(hv, "post_rst", 1);

    step();
    chk("grant_onehot_no_init_grant", 32'(bad_grant), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ad7763_ctrl_arbiter.md
Name: ad7763_ctrl_arbiter

Overview:
- Shares the single AD7763 serial control-word path between NUM_REQ requesters (e.g. AXI register write path, calibration engine, runtime gain/decimation updater).
- After reset, first issues a fixed power-up configuration sequence.
- Then grants requesters round-robin and forwards one 32-bit control word at a time to the downstream control-word serializer.
- Enforces completion (m_done), a timeout, and a minimum inter-word gap before the next grant.

Parameters:
- NUM_REQ, 2, number of requesters (1..8)
- GAP_CYCLES, 64, minimum aclk cycles between m_done and the next m_valid (1..65535)
- TIMEOUT_CYCLES, 4096, aclk cycles to wait for m_done after a handshake before abort (16..2^20)
- INIT_WORDS, 2, number of power-up words (0..4)
- INIT_WORD0..INIT_WORD3, 32'h0001_0002 / 32'h0002_0000 / 0 / 0, power-up words, [31:16]=register address, [15:0]=data

Ports:
- aclk  in  1  system clock
- aresetn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  32*NUM_REQ  per-requester word, requester i at [32*i+31:32*i]
- req_ready  out  NUM_REQ  one-hot acceptance, high for the single grant cycle only
- m_valid  out  1  word valid to serializer
- m_data  out  32  word to serializer
- m_ready  in  1  serializer accepts word
- m_done  in  1  one-cycle pulse, serializer finished shifting frame (already synchronized to aclk)
- busy  out  1  high in every state except IDLE
- init_done  out  1  power-up sequence complete
- grant_id  out  3  index of last granted requester, 7 while initializing
- err_timeout  out  1  sticky, m_done not received in time
- err_clr  in  1  clears err_timeout

Behaviour:
- Clock and reset: one clock, aclk. aresetn is asynchronous and active-low.
- Reset values: m_valid=0, m_data=0, req_ready=0, busy=1, init_done=0, grant_id=7, err_timeout=0, rr pointer=0. State is INIT_ISSUE if INIT_WORDS>0, else IDLE with init_done=1.
- INIT_ISSUE: m_valid=1, m_data=INIT_WORD[idx]. On m_valid&m_ready, go to WAIT_DONE.
- IDLE: busy=0.
  - If any req_valid, pick the first set bit at or after the rr pointer, cyclic.
  - Assert req_ready for that bit for exactly one cycle and latch req_data into m_data.
  - Set grant_id and rr pointer=grant+1 (mod NUM_REQ); go to ISSUE.
  - Grant-to-m_valid latency: 1 cycle.
- ISSUE: m_valid=1 and m_data held stable until m_ready. On handshake, go to WAIT_DONE.
- WAIT_DONE: timeout counter runs from 0.
  - m_done: go to GAP.
  - Counter reaches TIMEOUT_CYCLES-1 without m_done: set err_timeout, drop the word (no retry), go to GAP.
  - m_done arriving in the same cycle as the timeout: counts as done, no error.
- GAP: counter counts GAP_CYCLES cycles, then:
  - if initializing: idx+1; if idx==INIT_WORDS-1, set init_done=1 and go to IDLE, else go to INIT_ISSUE;
  - otherwise go to IDLE.
  - Earliest next m_valid after m_done: GAP_CYCLES+2 cycles (1 in IDLE for the grant).
- m_done outside WAIT_DONE is ignored.
- No requester is granted before init_done=1; req_ready stays 0 throughout.
- err_clr has priority over a simultaneous timeout set, and clears err_timeout.
- Reset mid-operation returns all state to reset values, and the init sequence restarts from word 0. Any word in flight at the serializer is not tracked.
- Requester drops req_valid without a grant: no effect. The arbiter never samples req_data except in the grant cycle.
- Counters: 16-bit gap counter, 20-bit timeout counter, no wrap (they saturate at terminal count).

Decomposition:
- Shared package ad7763_pkg:
  - state encoding (INIT_ISSUE, IDLE, ISSUE, WAIT_DONE, GAP);
  - control-word field constants (ADDR_MSB=31, ADDR_LSB=16, DATA_MSB=15);
  - AD7763 register addresses (REG_CTRL1=16'h0001, REG_CTRL2=16'h0002);
  - GRANT_INIT=3'd7.
- One sub-module, ad7763_rr_pick: combinational round-robin priority picker (req vector + pointer -> one-hot grant + index).

Test Plan:
- Reset, INIT_WORDS=2, serializer model with m_ready=1 and m_done 40 cycles after each handshake -> m_data 32'h0001_0002 then 32'h0002_0000. Second m_valid exactly GAP_CYCLES+1 cycles after the first m_done. Then init_done=1 and busy=0.
- NUM_REQ=2, both req_valid high continuously with data A=32'h0003_00AA, B=32'h0003_00BB -> grant order A,B,A,B. req_ready one-hot, one cycle per grant.
- m_ready held low 10 cycles in ISSUE -> m_valid and m_data stable throughout; handshake on the 11th cycle. No new grant in that time.
- m_done never returned -> err_timeout=1 after TIMEOUT_CYCLES cycles. GAP is entered, the next requester is served, and err_timeout stays 1 until an err_clr pulse clears it.
- m_done and err_clr coincident with timeout terminal count -> err_timeout stays 0.
- aresetn asserted during the GAP after requester 1 -> all outputs return to reset values immediately (async). After release, the init sequence restarts with INIT_WORD0, and rr pointer=0.
